// File: rtl/spell_mem_banked_pkg.sv
// Shared memory-type encodings for the spell core memory port.
package memtypes;

  localparam logic [1:0] MemoryTypeData   = 2'd0;
  localparam logic [1:0] MemoryTypeCode   = 2'd1;
  localparam logic [1:0] MemoryTypeIO     = 2'd2;
  localparam logic [1:0] MemoryTypeEEPROM = 2'd3;

endpackage

// File: rtl/spell_mem_banked_bank.sv
// Flip-flop storage bank: synchronous write-enable port, combinational read port.
module spell_mem_bank #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]         idx;
  logic                  in_range;

  // Local guard keeps non-power-of-two depths from indexing past the array.
  assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = addr[IW-1:0];
  assign rdata    = in_range ? mem_q[idx] : '1;

  always_ff @(posedge clock) begin
    if (we && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/spell_mem_banked.sv
// Banked code/data DFF memory with wait states, abort and error reporting.
// Optional: SPELL_MEM_CODE_WP_EN makes the code bank read-only.
module spell_mem_banked
  import memtypes::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int CODE_DEPTH  = 32,
  parameter int DATA_DEPTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  select,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            memory_type,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  error
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            type_q, type_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  commit;
  logic                  code_hit, data_hit;
  logic                  code_ok, data_ok, op_ok;
  logic                  code_we, data_we;
  logic [DATA_WIDTH-1:0] code_rdata, data_rdata;

  assign code_hit = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(CODE_DEPTH));
  assign data_hit = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DATA_DEPTH));
  assign commit   = (state_q == StAccess) && select && (cnt_q == '0);

  assign data_ok = (type_q == MemoryTypeData) && data_hit;
`ifdef SPELL_MEM_CODE_WP_EN
  assign code_ok = (type_q == MemoryTypeCode) && code_hit && !write_q;
`else
  assign code_ok = (type_q == MemoryTypeCode) && code_hit;
`endif
  assign op_ok = data_ok || code_ok;

  // Reset coinciding with the commit edge must not let the write land.
  assign data_we = commit && write_q && data_ok && !reset;
  assign code_we = commit && write_q && code_ok && !reset;

  spell_mem_bank #(
    .DEPTH      (CODE_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_code_bank (
    .clock (clock),
    .we    (code_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (code_rdata)
  );

  spell_mem_bank #(
    .DEPTH      (DATA_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_bank (
    .clock (clock),
    .we    (data_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (data_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    write_d = write_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (select) begin
          addr_d  = addr;
          type_d  = memory_type;
          write_d = write;
          wdata_d = data_in;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!select) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          err_d   = !op_ok;
          if (!write_q) begin
            if (!op_ok) begin
              dout_d = '1;
            end else if (type_q == MemoryTypeCode) begin
              dout_d = code_rdata;
            end else begin
              dout_d = data_rdata;
            end
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (!select) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign data_out   = dout_q;
  assign data_ready = ready_q;
  assign error      = err_q;

endmodule
